// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a settled lock, then releases the core reset.
// Optional lock-loss statistics counter is built only when PLL_LOCK_STATS_EN is defined.
module pll_lock_supervisor #(
  parameter int SETTLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int RST_PULSE     = 16,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       lock_ok,
  output logic       fail,
  output logic [7:0] lost_count
);

  localparam int PW = (RST_PULSE > 1)     ? $clog2(RST_PULSE)     : 1;
  localparam int TW = (LOCK_TIMEOUT > 1)  ? $clog2(LOCK_TIMEOUT)  : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [PW-1:0] PULSE_LAST   = PW'(RST_PULSE - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PLL_RESET,
    WAIT_LOCK,
    SETTLE,
    RUN,
    FAIL
  } state_e;

  state_e          state_q, state_d;
  logic            sync_q, lk_s_q;
  logic [PW-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic [TW-1:0]   timeout_cnt_q, timeout_cnt_d;
  logic [SW-1:0]   settle_cnt_q, settle_cnt_d, settle_inc;
  logic [RW-1:0]   retry_q, retry_d, retry_inc;
  logic            pll_rst_q, pll_rst_d;
  logic            core_reset_q, core_reset_d;
  logic            lock_ok_q, lock_ok_d;
  logic            fail_q, fail_d;

  assign settle_inc = settle_cnt_q + 1'b1;
  assign retry_inc  = retry_q + 1'b1;

  // The settle counter exits when its next value hits the last count, so RUN
  // is entered exactly SETTLE_CYCLES edges after lk_s first rises.
  always_comb begin
    state_d       = state_q;
    pulse_cnt_d   = pulse_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    settle_cnt_d  = settle_cnt_q;
    retry_d       = retry_q;
    case (state_q)
      PLL_RESET: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          state_d       = WAIT_LOCK;
          timeout_cnt_d = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lk_s_q) begin
          settle_cnt_d = '0;
          if (SETTLE_CYCLES == 1) begin
            state_d = RUN;
            retry_d = '0;
          end else begin
            state_d = SETTLE;
          end
        end else if (timeout_cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_inc;
          if (retry_inc == RETRY_MAX) begin
            state_d = FAIL;
          end else begin
            state_d     = PLL_RESET;
            pulse_cnt_d = '0;
          end
        end else begin
          timeout_cnt_d = timeout_cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        if (!lk_s_q) begin
          state_d       = WAIT_LOCK;
          timeout_cnt_d = '0;
        end else if (settle_inc == SETTLE_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end else begin
          settle_cnt_d = settle_inc;
        end
      end
      RUN: begin
        if (!lk_s_q) begin
          state_d     = PLL_RESET;
          pulse_cnt_d = '0;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d     = PLL_RESET;
        pulse_cnt_d = '0;
      end
    endcase

    pll_rst_d    = (state_d == PLL_RESET);
    core_reset_d = (state_d != RUN);
    lock_ok_d    = (state_d == RUN);
    fail_d       = (state_d == FAIL);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= 1'b0;
      lk_s_q        <= 1'b0;
      state_q       <= PLL_RESET;
      pulse_cnt_q   <= '0;
      timeout_cnt_q <= '0;
      settle_cnt_q  <= '0;
      retry_q       <= '0;
      pll_rst_q     <= 1'b1;
      core_reset_q  <= 1'b1;
      lock_ok_q     <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      sync_q        <= pll_locked;
      lk_s_q        <= sync_q;
      state_q       <= state_d;
      pulse_cnt_q   <= pulse_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      retry_q       <= retry_d;
      pll_rst_q     <= pll_rst_d;
      core_reset_q  <= core_reset_d;
      lock_ok_q     <= lock_ok_d;
      fail_q        <= fail_d;
    end
  end

  assign pll_rst    = pll_rst_q;
  assign core_reset = core_reset_q;
  assign lock_ok    = lock_ok_q;
  assign fail       = fail_q;

`ifdef PLL_LOCK_STATS_EN
  logic [7:0] lost_count_q, lost_count_d;

  // A loss is the RUN -> PLL_RESET transition; the count saturates at 255.
  always_comb begin
    lost_count_d = lost_count_q;
    if (state_q == RUN && !lk_s_q && lost_count_q != 8'hFF) begin
      lost_count_d = lost_count_q + 8'd1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lost_count_q <= 8'd0;
    end else begin
      lost_count_q <= lost_count_d;
    end
  end

  assign lost_count = lost_count_q;
`else
  assign lost_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: expected output snapshots are queued per cycle
// from the timing rules and compared at the falling edge of refclk.
module tb_pll_lock_supervisor;

  localparam int SETTLE_CYCLES = 8;
  localparam int LOCK_TIMEOUT  = 32;
  localparam int RST_PULSE     = 4;
  localparam int MAX_RETRIES   = 2;

`ifdef PLL_LOCK_STATS_EN
  localparam logic [7:0] LOST_AFTER_ONE = 8'd1;
`else
  localparam logic [7:0] LOST_AFTER_ONE = 8'd0;
`endif

  logic       refclk     = 1'b0;
  logic       rst_n      = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       core_reset;
  logic       lock_ok;
  logic       fail;
  logic [7:0] lost_count;

  pll_lock_supervisor #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .RST_PULSE    (RST_PULSE),
    .MAX_RETRIES  (MAX_RETRIES)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .core_reset(core_reset),
    .lock_ok   (lock_ok),
    .fail      (fail),
    .lost_count(lost_count)
  );

  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic       prst;
    logic       crst;
    logic       lok;
    logic       fl;
    logic [7:0] lost;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void push_exp(input int c, input string nm, input logic prst,
                                   input logic crst, input logic lok, input logic fl,
                                   input logic [7:0] lost);
    exp_t e;
    e.cyc  = c;
    e.name = nm;
    e.prst = prst;
    e.crst = crst;
    e.lok  = lok;
    e.fl   = fl;
    e.lost = lost;
    sb.push_back(e);
  endfunction

  // Pulse rst_n low for one cycle and release it between edges; c0 is the cycle
  // count at release, so the first active edge is c0+1.
  task automatic restart(output int c0);
    @(negedge refclk);
    rst_n = 1'b0;
    @(negedge refclk);
    rst_n = 1'b1;
    c0 = cyc;
  endtask

  task automatic test_reset();
    exp_t e;
    #2 rst_n = 1'b0;
    push_exp(cyc + 2, "reset_values", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge refclk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if ({pll_rst, core_reset, lock_ok, fail, lost_count} !== {e.prst, e.crst, e.lok, e.fl, e.lost} || e.cyc != cyc) begin
          n_fail++;
          $display("[TB] FAIL %s @%0d (due %0d): got rst=%b core=%b ok=%b fail=%b lost=%0d, want rst=%b core=%b ok=%b fail=%b lost=%0d",
                   e.name, cyc, e.cyc, pll_rst, core_reset, lock_ok, fail, lost_count, e.prst, e.crst, e.lok, e.fl, e.lost);
        end
      end
    end
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL reset_leftover: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_clean_lock();
    exp_t e;
    int   c0;
    pll_locked = 1'b0;
    restart(c0);
    push_exp(c0 + 1,  "clean_pulse_first", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(c0 + 3,  "clean_pulse_last",  1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(c0 + 4,  "clean_pulse_end",   1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(c0 + 23, "clean_pre_release", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(c0 + 24, "clean_release",     1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 26; i++) begin
      @(negedge refclk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if ({pll_rst, core_reset, lock_ok, fail, lost_count} !== {e.prst, e.crst, e.lok, e.fl, e.lost} || e.cyc != cyc) begin
          n_fail++;
          $display("[TB] FAIL %s @%0d (due %0d): got rst=%b core=%b ok=%b fail=%b lost=%0d, want rst=%b core=%b ok=%b fail=%b lost=%0d",
                   e.name, cyc, e.cyc, pll_rst, core_reset, lock_ok, fail, lost_count, e.prst, e.crst, e.lok, e.fl, e.lost);
        end
      end
      if (cyc == c0 + 14) pll_locked = 1'b1;
    end
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL clean_leftover: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_loss_in_run();
    exp_t e;
    int   c1;
    @(negedge refclk);
    c1 = cyc;
    pll_locked = 1'b0;
    push_exp(c1 + 2,  "loss_run_hold",   1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    push_exp(c1 + 3,  "loss_detect",     1'b1, 1'b1, 1'b0, 1'b0, LOST_AFTER_ONE);
    push_exp(c1 + 6,  "loss_pulse_last", 1'b1, 1'b1, 1'b0, 1'b0, LOST_AFTER_ONE);
    push_exp(c1 + 7,  "loss_pulse_end",  1'b0, 1'b1, 1'b0, 1'b0, LOST_AFTER_ONE);
    push_exp(c1 + 18, "loss_relock",     1'b0, 1'b0, 1'b1, 1'b0, LOST_AFTER_ONE);
    for (int i = 0; i < 20; i++) begin
      @(negedge refclk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if ({pll_rst, core_reset, lock_ok, fail, lost_count} !== {e.prst, e.crst, e.lok, e.fl, e.lost} || e.cyc != cyc) begin
          n_fail++;
          $display("[TB] FAIL %s @%0d (due %0d): got rst=%b core=%b ok=%b fail=%b lost=%0d, want rst=%b core=%b ok=%b fail=%b lost=%0d",
                   e.name, cyc, e.cyc, pll_rst, core_reset, lock_ok, fail, lost_count, e.prst, e.crst, e.lok, e.fl, e.lost);
        end
      end
      if (cyc == c1 + 8) pll_locked = 1'b1;
    end
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL loss_leftover: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  // lk_s is low for one cycle while the settle count is 5; release would have
  // been at c0+14 without the glitch and moves to 8 lk_s-high edges after it.
  task automatic test_settle_glitch();
    exp_t e;
    int   c0;
    pll_locked = 1'b0;
    restart(c0);
    push_exp(c0 + 14, "glitch_no_early_release", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(c0 + 20, "glitch_pre_release",      1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(c0 + 21, "glitch_release",          1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 23; i++) begin
      @(negedge refclk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if ({pll_rst, core_reset, lock_ok, fail, lost_count} !== {e.prst, e.crst, e.lok, e.fl, e.lost} || e.cyc != cyc) begin
          n_fail++;
          $display("[TB] FAIL %s @%0d (due %0d): got rst=%b core=%b ok=%b fail=%b lost=%0d, want rst=%b core=%b ok=%b fail=%b lost=%0d",
                   e.name, cyc, e.cyc, pll_rst, core_reset, lock_ok, fail, lost_count, e.prst, e.crst, e.lok, e.fl, e.lost);
        end
      end
      if (cyc == c0 + 4)  pll_locked = 1'b1;
      if (cyc == c0 + 10) pll_locked = 1'b0;
      if (cyc == c0 + 11) pll_locked = 1'b1;
    end
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL glitch_leftover: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  // WAIT_LOCK starts at c0+4, so its final cycle is decided at c0+36; lk_s rises at c0+35.
  task automatic test_tiebreak();
    exp_t e;
    int   c0;
    pll_locked = 1'b0;
    restart(c0);
    push_exp(c0 + 35, "tie_wait_last", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(c0 + 36, "tie_no_retry",  1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(c0 + 42, "tie_pre",       1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(c0 + 43, "tie_release",   1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 45; i++) begin
      @(negedge refclk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if ({pll_rst, core_reset, lock_ok, fail, lost_count} !== {e.prst, e.crst, e.lok, e.fl, e.lost} || e.cyc != cyc) begin
          n_fail++;
          $display("[TB] FAIL %s @%0d (due %0d): got rst=%b core=%b ok=%b fail=%b lost=%0d, want rst=%b core=%b ok=%b fail=%b lost=%0d",
                   e.name, cyc, e.cyc, pll_rst, core_reset, lock_ok, fail, lost_count, e.prst, e.crst, e.lok, e.fl, e.lost);
        end
      end
      if (cyc == c0 + 33) pll_locked = 1'b1;
    end
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL tie_leftover: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_timeout_fail();
    exp_t e;
    int   c0;
    pll_locked = 1'b0;
    restart(c0);
    push_exp(c0 + 4,  "to_wait1_start",  1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(c0 + 35, "to_wait1_last",   1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(c0 + 36, "to_retry_pulse",  1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(c0 + 39, "to_retry_last",   1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(c0 + 40, "to_wait2_start",  1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(c0 + 71, "to_wait2_last",   1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(c0 + 72, "to_fail",         1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
    push_exp(c0 + 90, "to_fail_sticky",  1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 92; i++) begin
      @(negedge refclk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if ({pll_rst, core_reset, lock_ok, fail, lost_count} !== {e.prst, e.crst, e.lok, e.fl, e.lost} || e.cyc != cyc) begin
          n_fail++;
          $display("[TB] FAIL %s @%0d (due %0d): got rst=%b core=%b ok=%b fail=%b lost=%0d, want rst=%b core=%b ok=%b fail=%b lost=%0d",
                   e.name, cyc, e.cyc, pll_rst, core_reset, lock_ok, fail, lost_count, e.prst, e.crst, e.lok, e.fl, e.lost);
        end
      end
      if (cyc == c0 + 75) pll_locked = 1'b1;
    end
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL to_leftover: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int   c0;
    int   c2;
    pll_locked = 1'b0;
    restart(c0);
    push_exp(c0 + 9, "async_in_settle", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 9; i++) begin
      @(negedge refclk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if ({pll_rst, core_reset, lock_ok, fail, lost_count} !== {e.prst, e.crst, e.lok, e.fl, e.lost} || e.cyc != cyc) begin
          n_fail++;
          $display("[TB] FAIL %s @%0d (due %0d): got rst=%b core=%b ok=%b fail=%b lost=%0d, want rst=%b core=%b ok=%b fail=%b lost=%0d",
                   e.name, cyc, e.cyc, pll_rst, core_reset, lock_ok, fail, lost_count, e.prst, e.crst, e.lok, e.fl, e.lost);
        end
      end
      if (cyc == c0 + 4) pll_locked = 1'b1;
    end
    // Short rst_n pulse entirely inside the low phase of refclk: no edge occurs.
    #1 rst_n = 1'b0;
    #1;
    push_exp(cyc, "async_immediate", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if ({pll_rst, core_reset, lock_ok, fail, lost_count} !== {e.prst, e.crst, e.lok, e.fl, e.lost}) begin
        n_fail++;
        $display("[TB] FAIL %s: got rst=%b core=%b ok=%b fail=%b lost=%0d, want rst=%b core=%b ok=%b fail=%b lost=%0d",
                 e.name, pll_rst, core_reset, lock_ok, fail, lost_count, e.prst, e.crst, e.lok, e.fl, e.lost);
      end
    end
    #1 rst_n = 1'b1;
    c2 = cyc;
    push_exp(c2 + 1,  "async_pulse_first", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(c2 + 3,  "async_pulse_last",  1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(c2 + 4,  "async_pulse_end",   1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(c2 + 11, "async_pre_release", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(c2 + 12, "async_release",     1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 14; i++) begin
      @(negedge refclk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if ({pll_rst, core_reset, lock_ok, fail, lost_count} !== {e.prst, e.crst, e.lok, e.fl, e.lost} || e.cyc != cyc) begin
          n_fail++;
          $display("[TB] FAIL %s @%0d (due %0d): got rst=%b core=%b ok=%b fail=%b lost=%0d, want rst=%b core=%b ok=%b fail=%b lost=%0d",
                   e.name, cyc, e.cyc, pll_rst, core_reset, lock_ok, fail, lost_count, e.prst, e.crst, e.lok, e.fl, e.lost);
        end
      end
    end
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL async_leftover: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_loss_in_run();
    test_settle_glitch();
    test_tiebreak();
    test_timeout_fail();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached before the end of the sequence");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervises the lock handshake of the core's clock PLL from the PLL's reference-clock side. Drives the PLL `rst` input, watches its `locked` output, and sequences a clean core reset. The core comes out of reset only after lock has been stable for a programmable settle time. On loss of lock the block re-resets the PLL, and after repeated lock timeouts it enters a terminal fail state.

## Interface
Parameters:
- `SETTLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before releasing the core (≥1).
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before a retry (1 ms at 50 MHz).
- `RST_PULSE`, 16: width in cycles of each `pll_rst` pulse (≥1).
- `MAX_RETRIES`, 7: lock timeouts tolerated before FAIL (1..255).

Ports:
- `refclk` in 1: free-running reference clock (the PLL's input clock).
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL lock flag, asynchronous to `refclk`.
- `pll_rst` out 1: active-high reset to the PLL.
- `core_reset` out 1: active-high reset to the core clock domain consumers.
- `lock_ok` out 1: high while in RUN.
- `fail` out 1: high while in FAIL.
- `lost_count` out 8: saturating count of lock losses seen in RUN.

## Operation
- `pll_locked` passes through a 2-flop synchronizer (`lk_s`). Every decision uses `lk_s`.
- The FSM has five states: PLL_RESET, WAIT_LOCK, SETTLE, RUN, FAIL.
- **PLL_RESET**
  - `pll_rst`=1 and a pulse counter runs.
  - After `RST_PULSE` cycles → WAIT_LOCK. The timeout counter clears on entry.
- **WAIT_LOCK**
  - `lk_s`=1 → SETTLE, with the settle counter cleared.
  - Timeout counter reaches `LOCK_TIMEOUT`-1 with `lk_s`=0 → retry counter increments. If the new value equals `MAX_RETRIES` → FAIL, otherwise → PLL_RESET.
- **SETTLE**
  - The settle counter increments while `lk_s`=1.
  - `lk_s`=0 → WAIT_LOCK with the timeout restarted. This does not count as a retry or a loss.
  - Counter reaches `SETTLE_CYCLES`-1 with `lk_s`=1 → RUN. The retry counter clears.
- **RUN**
  - `lk_s`=0 → `lost_count` increments (saturates at 255) → PLL_RESET.
- **FAIL**
  - Terminal state: `pll_rst`=0, `core_reset`=1, `fail`=1.
  - Exited only by `rst_n`.
- `core_reset`=1 in every state except RUN.
- All outputs are registered, decoded from the next state, so they change in the same edge as the state.
- Counters are sized with `$clog2` of their parameter. No wrap-around is possible because each counter is bounded by its state exit.

## Timing
- **Reset values:** FSM=PLL_RESET, `pll_rst`=1, `core_reset`=1, `lock_ok`=0, `fail`=0, `lost_count`=0, synchronizer=0, all counters=0.
- **First pulse after reset:** `rst_n` deassertion at edge 0 → `pll_rst` stays high through edge `RST_PULSE`-1 and falls at edge `RST_PULSE`.
- **Lock detection latency:** a `pll_locked` rise is seen as `lk_s` 2 edges later.
- **Core release:** `core_reset` falls `SETTLE_CYCLES` edges after `lk_s` first rises. `lock_ok` rises on that same edge.
- **Loss of lock:** a `pll_locked` fall during RUN gives `core_reset`=1, `pll_rst`=1 and `lost_count`+1, all on the edge after `lk_s` falls (3 edges after the input falls).
- **Simultaneous events:** timeout expiry coinciding with `lk_s` rising → the lock wins and the FSM goes to SETTLE.
- **Reset mid-operation:** `rst_n` low at any point forces reset values immediately and asynchronously. A fresh PLL_RESET pulse follows release.

## Configuration
- **`PLL_LOCK_STATS_EN` defined:** the `lost_count` register and its saturating increment are built.
- **Not defined:** `lost_count` is tied to 8'd0 and no counter logic is synthesized. All other behaviour is identical.

## Test plan
Bench parameters for all scenarios: `SETTLE_CYCLES`=8, `LOCK_TIMEOUT`=32, `RST_PULSE`=4, `MAX_RETRIES`=2.
- **Clean lock:** release `rst_n`; `pll_locked` rises 10 cycles after `pll_rst` falls → `pll_rst` is high for exactly 4 cycles, and `core_reset` falls 10 edges after `pll_locked` rises (2 sync + 8 settle) with `lock_ok`=1.
- **Settle glitch:** `pll_locked` drops for 1 cycle at settle count 5 → no retry and no `lost_count` change; release occurs 8 full `lk_s`-high cycles after the glitch.
- **Loss in RUN:** drop `pll_locked` while in RUN → `core_reset`=1 and a 4-cycle `pll_rst` pulse; `lost_count`=1 when stats are enabled, 0 when disabled.
- **Timeouts → FAIL:** hold `pll_locked`=0 → two 32-cycle waits separated by one `pll_rst` pulse, then `fail`=1, `pll_rst`=0 and `core_reset`=1 held indefinitely. Re-asserting `pll_locked` in FAIL has no effect.
- **Tie-break:** `lk_s` rises on the timeout's final cycle → the FSM enters SETTLE and the retry counter is unchanged.
- **Async reset mid-SETTLE:** pulse `rst_n` low for less than 1 cycle → outputs go to reset values immediately, without waiting for a clock edge, and the sequence restarts with a 4-cycle `pll_rst` pulse.
